// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sched
// Desc     : Two-lane round-robin request scheduler for the shared
//            multiply/divide unit. Queues accepted requests in a small FIFO,
//            dispatches one at a time, tracks the in-flight request until the
//            unit drops busy, and exports a destination-register pending mask.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sched #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_vld,
    input  logic [63:0] req_instr,
    input  logic [63:0] req_pc,
    input  logic [63:0] req_rs0,
    input  logic [63:0] req_rs1,
    output logic [1:0]  req_rdy,
    input  logic        flush,
    output logic        unit_vld,
    output logic [31:0] unit_instr,
    output logic [31:0] unit_pc,
    output logic [31:0] unit_rs0,
    output logic [31:0] unit_rs1,
    input  logic        unit_busy,
    output logic        done,
    output logic [4:0]  done_rd,
    output logic        done_lane,
    output logic [31:0] pend_mask,
    output logic        sched_busy
);

    localparam int                c_ADDR_W  = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL    = (c_ADDR_W + 1)'(DEPTH);

    localparam logic [1:0]        c_ST_IDLE = 2'd0;
    localparam logic [1:0]        c_ST_ARM  = 2'd1;
    localparam logic [1:0]        c_ST_RUN  = 2'd2;

    // FIFO storage and bookkeeping
    logic [31:0]         r_instr [DEPTH];
    logic [31:0]         r_pc    [DEPTH];
    logic [31:0]         r_rs0   [DEPTH];
    logic [31:0]         r_rs1   [DEPTH];
    logic [DEPTH-1:0]    r_lane;
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;

    // Arbitration and in-flight tracking
    logic                r_rr;
    logic [1:0]          r_state;
    logic [4:0]          r_inf_rd;
    logic                r_inf_lane;

    logic [1:0]          w_grant;
    logic                w_push;
    logic                w_push_lane;
    logic                w_pop;
    logic [31:0]         w_pend;

    // Round-robin grant: a lone requester wins outright, a tie goes to r_rr
    always_comb begin
        w_grant[0] = req_vld[0] & (~req_vld[1] | ~r_rr);
        w_grant[1] = req_vld[1] & (~req_vld[0] |  r_rr);
    end

    // Full FIFO never accepts, even when the head pops in the same cycle
    assign req_rdy     = w_grant & {2{(r_count < c_FULL) & ~flush}};
    assign w_push      = |(req_vld & req_rdy);
    assign w_push_lane = w_grant[1];

    // Dispatch is held off during the done cycle so back-to-back issue
    // starts no earlier than the cycle after the retire pulse
    assign unit_vld   = (r_state == c_ST_IDLE) & (r_count != '0) & ~unit_busy
                      & ~flush & ~done;
    assign w_pop      = unit_vld;
    assign unit_instr = r_instr[r_rd_ptr];
    assign unit_pc    = r_pc[r_rd_ptr];
    assign unit_rs0   = r_rs0[r_rd_ptr];
    assign unit_rs1   = r_rs1[r_rd_ptr];
    assign sched_busy = (r_count != '0) | (r_state != c_ST_IDLE);

    // Pending mask: live FIFO slots plus the in-flight request; x0 never pends
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, c_ADDR_W'(i) - r_rd_ptr} < r_count) begin
                w_pend = w_pend | (32'd1 << r_instr[i][11:7]);
            end
        end
        if (r_state != c_ST_IDLE) begin
            w_pend = w_pend | (32'd1 << r_inf_rd);
        end
        w_pend[0] = 1'b0;
    end
    assign pend_mask = w_pend;

    // Round-robin pointer toggles on every accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_push) begin
            r_rr <= ~r_rr;
        end
    end

    // FIFO: write at tail, pop at head; flush empties without touching storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_lane   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
                r_rs0[i]   <= '0;
                r_rs1[i]   <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= w_push_lane ? req_instr[63:32] : req_instr[31:0];
                r_pc[r_wr_ptr]    <= w_push_lane ? req_pc[63:32]    : req_pc[31:0];
                r_rs0[r_wr_ptr]   <= w_push_lane ? req_rs0[63:32]   : req_rs0[31:0];
                r_rs1[r_wr_ptr]   <= w_push_lane ? req_rs1[63:32]   : req_rs1[31:0];
                r_lane[r_wr_ptr]  <= w_push_lane;
                r_wr_ptr          <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Dispatch/track FSM; retire raises a registered one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_inf_rd   <= '0;
            r_inf_lane <= 1'b0;
            done       <= 1'b0;
            done_rd    <= '0;
            done_lane  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (unit_vld) begin
                        r_inf_rd   <= unit_instr[11:7];
                        r_inf_lane <= r_lane[r_rd_ptr];
                        r_state    <= c_ST_ARM;
                    end
                end
                c_ST_ARM, c_ST_RUN: begin
                    // ARM normally sees busy rise; a low here is retired anyway
                    if (unit_busy) begin
                        r_state <= c_ST_RUN;
                    end else begin
                        r_state   <= c_ST_IDLE;
                        done      <= 1'b1;
                        done_rd   <= r_inf_rd;
                        done_lane <= r_inf_lane;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sched
// Desc     : Self-checking bench for mdu_sched: directed scenarios followed by
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  req_vld;
    logic [63:0] req_instr, req_pc, req_rs0, req_rs1;
    logic [1:0]  req_rdy;
    logic        flush;
    logic        unit_vld;
    logic [31:0] unit_instr, unit_pc, unit_rs0, unit_rs1;
    logic        unit_busy;
    logic        done;
    logic [4:0]  done_rd;
    logic        done_lane;
    logic [31:0] pend_mask;
    logic        sched_busy;

    mdu_sched #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_instr  (req_instr),
        .req_pc     (req_pc),
        .req_rs0    (req_rs0),
        .req_rs1    (req_rs1),
        .req_rdy    (req_rdy),
        .flush      (flush),
        .unit_vld   (unit_vld),
        .unit_instr (unit_instr),
        .unit_pc    (unit_pc),
        .unit_rs0   (unit_rs0),
        .unit_rs1   (unit_rs1),
        .unit_busy  (unit_busy),
        .done       (done),
        .done_rd    (done_rd),
        .done_lane  (done_lane),
        .pend_mask  (pend_mask),
        .sched_busy (sched_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: queue of accepted requests plus one in-flight slot
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs0;
        logic [31:0] rs1;
        logic        lane;
    } ent_t;

    ent_t       q[$];
    logic       m_rr, m_inf, m_inf_lane, m_done, m_done_lane;
    logic [4:0] m_inf_rd, m_done_rd;
    int         busy_cnt;
    int         next_lat;
    bit         rand_lat;
    bit         spur;

    int n_cmp;
    int n_err;

    // Snapshot of the DUT outputs from the most recent cycle
    logic [1:0]  o_rdy;
    logic        o_uv, o_done, o_lane, o_sbusy;
    logic [4:0]  o_rd;
    logic [31:0] o_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rr = 1'b0; m_inf = 1'b0; m_inf_lane = 1'b0; m_inf_rd = '0;
        m_done = 1'b0; m_done_rd = '0; m_done_lane = 1'b0;
        busy_cnt = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdy"},   32'(req_rdy),    32'd0);
        check({tag, "_uvld"},  32'(unit_vld),   32'd0);
        check({tag, "_instr"}, unit_instr,      32'd0);
        check({tag, "_pc"},    unit_pc,         32'd0);
        check({tag, "_rs0"},   unit_rs0,        32'd0);
        check({tag, "_rs1"},   unit_rs1,        32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_drd"},   32'(done_rd),    32'd0);
        check({tag, "_dlane"}, 32'(done_lane),  32'd0);
        check({tag, "_pend"},  pend_mask,       32'd0);
        check({tag, "_sbusy"}, 32'(sched_busy), 32'd0);
    endtask

    // Asynchronous reset applied mid-cycle (called at a falling edge)
    task automatic apply_reset(input string tag);
        req_vld = 2'b00; flush = 1'b0; unit_busy = 1'b0; spur = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset(tag);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_req(input int lane, input logic [4:0] rd);
        logic [31:0] ins;
        ins = $urandom;
        ins[11:7] = rd;
        ins[6:0]  = 7'b0110011;
        req_instr[32*lane +: 32] = ins;
        req_pc[32*lane +: 32]    = $urandom;
        req_rs0[32*lane +: 32]   = $urandom;
        req_rs1[32*lane +: 32]   = $urandom;
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic cyc(input logic [1:0] vld, input logic fl);
        logic [1:0]  g, e_rdy;
        logic        e_uvld, new_done;
        logic [31:0] e_pend;
        ent_t        e;
        req_vld   = vld;
        flush     = fl;
        unit_busy = (busy_cnt > 0) || spur;
        #1;
        g = (vld == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : vld;
        e_rdy  = (q.size() < DEPTH && !fl) ? g : 2'b00;
        e_uvld = !m_inf && !m_done && (q.size() != 0) && !unit_busy && !fl;
        e_pend = '0;
        foreach (q[k]) e_pend = e_pend | (32'd1 << q[k].instr[11:7]);
        if (m_inf) e_pend = e_pend | (32'd1 << m_inf_rd);
        e_pend[0] = 1'b0;

        check("req_rdy",    32'(req_rdy),    32'(e_rdy));
        check("unit_vld",   32'(unit_vld),   32'(e_uvld));
        if (q.size() != 0) begin
            check("unit_instr", unit_instr, q[0].instr);
            check("unit_pc",    unit_pc,    q[0].pc);
            check("unit_rs0",   unit_rs0,   q[0].rs0);
            check("unit_rs1",   unit_rs1,   q[0].rs1);
        end
        check("done",       32'(done),       32'(m_done));
        check("done_rd",    32'(done_rd),    32'(m_done_rd));
        check("done_lane",  32'(done_lane),  32'(m_done_lane));
        check("pend_mask",  pend_mask,       e_pend);
        check("sched_busy", 32'(sched_busy), 32'((q.size() != 0) || m_inf));

        o_rdy = req_rdy; o_uv = unit_vld; o_done = done; o_rd = done_rd;
        o_lane = done_lane; o_pend = pend_mask; o_sbusy = sched_busy;

        @(posedge clk);
        new_done = m_inf && !unit_busy;
        if (new_done) begin
            m_inf = 1'b0;
            m_done_rd = m_inf_rd;
            m_done_lane = m_inf_lane;
        end
        m_done = new_done;
        if (busy_cnt > 0) busy_cnt--;
        if (fl) begin
            q.delete();
        end else begin
            if (e_uvld) begin
                e = q.pop_front();
                m_inf = 1'b1;
                m_inf_rd = e.instr[11:7];
                m_inf_lane = e.lane;
                busy_cnt = rand_lat ? int'($urandom_range(0, 4)) : next_lat;
            end
            if (e_rdy != 2'b00) begin
                e.instr = e_rdy[1] ? req_instr[63:32] : req_instr[31:0];
                e.pc    = e_rdy[1] ? req_pc[63:32]    : req_pc[31:0];
                e.rs0   = e_rdy[1] ? req_rs0[63:32]   : req_rs0[31:0];
                e.rs1   = e_rdy[1] ? req_rs1[63:32]   : req_rs1[31:0];
                e.lane  = e_rdy[1];
                q.push_back(e);
                m_rr = ~m_rr;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rand_lat = 1'b0; next_lat = 0; spur = 1'b0;
        req_instr = '0; req_pc = '0; req_rs0 = '0; req_rs1 = '0;
        rst = 1'b0;
        model_reset();
        apply_reset("rst0");

        // Single request, lane 0, rd=5, unit busy for 4 cycles
        next_lat = 4;
        set_req(0, 5'd5);
        for (int k = 0; k < 9; k++) begin
            cyc((k == 0) ? 2'b01 : 2'b00, 1'b0);
            if (k == 0) check("single_acc", 32'(o_rdy), 32'd1);
            if (k == 1) check("single_disp", 32'(o_uv), 32'd1);
            check("single_pend5", 32'(o_pend[5]), 32'((k >= 1) && (k <= 6)));
            check("single_done", 32'(o_done), 32'(k == 7));
            if (k == 7) begin
                check("single_drd", 32'(o_rd), 32'd5);
                check("single_dlane", 32'(o_lane), 32'd0);
            end
        end

        // Contention from rr=0: accepts alternate, full FIFO stalls both lanes
        apply_reset("rst1");
        next_lat = 2;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 5'($urandom_range(1, 31)));
            set_req(1, 5'($urandom_range(1, 31)));
            cyc(2'b11, 1'b0);
            if (k == 0) check("cont_acc0", 32'(o_rdy), 32'd1);
            if (k == 1) check("cont_acc1", 32'(o_rdy), 32'd2);
            if (k == 2) check("cont_acc2", 32'(o_rdy), 32'd1);
            if (k == 3) check("cont_full", 32'(o_rdy), 32'd0);
        end
        idle(14);

        // Direct-result op: busy for one cycle, next entry follows the done
        next_lat = 1;
        set_req(0, 5'd3);
        set_req(1, 5'd4);
        for (int k = 0; k < 7; k++) begin
            cyc((k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b00), 1'b0);
            if (k == 1) check("dr_disp0", 32'(o_uv), 32'd1);
            if (k == 4) begin
                check("dr_done", 32'(o_done), 32'd1);
                check("dr_nodisp", 32'(o_uv), 32'd0);
            end
            if (k == 5) check("dr_disp1", 32'(o_uv), 32'd1);
        end
        idle(8);

        // Flush with two queued and one in flight
        next_lat = 6;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) set_req(0, 5'd7);
            if (k == 1) set_req(1, 5'd9);
            if (k == 2) set_req(0, 5'd10);
            case (k)
                0:       cyc(2'b01, 1'b0);
                1:       cyc(2'b10, 1'b0);
                2:       cyc(2'b01, 1'b0);
                3:       cyc(2'b11, 1'b1);
                default: cyc(2'b00, 1'b0);
            endcase
            if (k == 3) check("fl_rdy", 32'(o_rdy), 32'd0);
            if (k >= 3) check("fl_nodisp", 32'(o_uv), 32'd0);
            if (k == 4) check("fl_pend", o_pend, 32'h0000_0080);
            if (k == 9) begin
                check("fl_done", 32'(o_done), 32'd1);
                check("fl_drd", 32'(o_rd), 32'd7);
            end
        end

        // rd=0 request: completes normally, never shows as pending
        next_lat = 2;
        set_req(0, 5'd0);
        for (int k = 0; k < 8; k++) begin
            cyc((k == 0) ? 2'b01 : 2'b00, 1'b0);
            check("rd0_pend", o_pend, 32'd0);
            check("rd0_done", 32'(o_done), 32'(k == 5));
        end

        // Asynchronous reset while the unit is in RUN; no done may follow
        next_lat = 5;
        set_req(1, 5'd12);
        cyc(2'b10, 1'b0);
        idle(3);
        check("run_sbusy", 32'(o_sbusy), 32'd1);
        apply_reset("rst_run");
        for (int k = 0; k < 8; k++) begin
            cyc(2'b00, 1'b0);
            check("rst_nodone", 32'(o_done), 32'd0);
        end

        // Randomized traffic
        rand_lat = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            set_req(0, 5'($urandom_range(0, 31)));
            set_req(1, 5'($urandom_range(0, 31)));
            spur = ($urandom_range(0, 9) == 0);
            cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0));
        end
        spur = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
